// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder; the only arithmetic used by the serial adder.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  // Pure combinational full-adder equations
  always_comb begin
    Sum  = A ^ B ^ Cin;
    Cout = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: processes one bit per cycle LSB first, done pulses WIDTH
// cycles after start is accepted. Legal WIDTH range is 2..64.
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_bit;
  logic             fa_sum, fa_cout;

  fa_cell u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Cin (carry_q),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = (cnt_q == CntLast);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath: load on acceptance, shift one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
      carry_q <= fa_cout;
      // Hold on the last bit so the counter never wraps
      if (!last_bit) cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized bench for serial_add_ctrl (WIDTH 8, plus 2 and 16).
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic [15:0] wa, wb;
  logic        wcin, wstart;
  logic        w16_busy, w16_done, w16_cout;
  logic [15:0] w16_sum;
  logic        w2_busy, w2_done, w2_cout;
  logic [1:0]  w2_sum;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  serial_add_ctrl #(.WIDTH(16)) u_w16 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(wstart),
    .a    (wa),
    .b    (wb),
    .cin  (wcin),
    .busy (w16_busy),
    .done (w16_done),
    .sum  (w16_sum),
    .cout (w16_cout)
  );

  serial_add_ctrl #(.WIDTH(2)) u_w2 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(wstart),
    .a    (wa[1:0]),
    .b    (wb[1:0]),
    .cin  (wcin),
    .busy (w2_busy),
    .done (w2_done),
    .sum  (w2_sum),
    .cout (w2_cout)
  );

  // Drive one accepted start; returns at the negedge right after the accepting edge
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles until done, bounded
  task automatic wait_done(input int maxc, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < maxc) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) $display("FAIL reset_outputs got=%h want=0",
                                                    {busy, done, sum, cout});
    else passed++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc;
    start_op(8'h5A, 8'h3C, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy0 busy=%b done=%b want 1/0",
                                                 busy, done);
    else passed++;
    wait_done(20, lat, bc);
    checks++;
    if (lat !== 8) $display("FAIL basic_latency got=%0d want=8", lat); else passed++;
    checks++;
    if (bc !== 8) $display("FAIL basic_busy_cycles got=%0d want=8", bc); else passed++;
    checks++;
    if (sum !== 8'h96 || cout !== 1'b0) $display("FAIL basic_sum got=%b_%h want=0_96", cout, sum);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h96)
      $display("FAIL basic_hold busy=%b done=%b sum=%h want 0/0/96", busy, done, sum);
    else passed++;
  endtask

  task automatic test_carry;
    int lat, bc;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(20, lat, bc);
    checks++;
    if (lat !== 8 || sum !== 8'h00 || cout !== 1'b1)
      $display("FAIL carry_ff_01 lat=%0d got=%b_%h want lat=8 1_00", lat, cout, sum);
    else passed++;
    start_op(8'hFF, 8'h00, 1'b1);
    wait_done(20, lat, bc);
    checks++;
    if (lat !== 8 || sum !== 8'h00 || cout !== 1'b1)
      $display("FAIL carry_cin lat=%0d got=%b_%h want lat=8 1_00", lat, cout, sum);
    else passed++;
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int first = -1;
    logic [8:0] res = '0;
    start_op(8'h5A, 8'h3C, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) begin
        a = 8'h11; b = 8'h22; start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          res = {cout, sum};
        end
      end
    end
    checks++;
    if (ndone !== 1 || first !== 8) $display("FAIL ignore_done count=%0d at=%0d want 1 at 8",
                                             ndone, first);
    else passed++;
    checks++;
    if (res !== 9'h096 || sum !== 8'h96) $display("FAIL ignore_sum got=%h held=%h want=096/96",
                                                  res, sum);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc, k;
    start_op(8'h01, 8'h02, 1'b0);
    start = 1'b1;
    wait_done(20, lat, bc);
    checks++;
    if (lat !== 8 || sum !== 8'h03) $display("FAIL b2b_first lat=%0d sum=%h want 8/03", lat, sum);
    else passed++;
    a = 8'h10; b = 8'h20; cin = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL b2b_no_gap busy=%b want=1", busy); else passed++;
      end
    end while (!done && k < 20);
    start = 1'b0;
    checks++;
    if (k !== 9) $display("FAIL b2b_spacing got=%0d want=9", k); else passed++;
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0) $display("FAIL b2b_second got=%b_%h want=0_30", cout, sum);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle busy=%b done=%b want 0/0",
                                                  busy, done);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    int nd = 0;
    int lat, bc;
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) $display("FAIL midrun_reset got=%h want=0",
                                                    {busy, done, sum, cout});
    else passed++;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) $display("FAIL midrun_no_done got=%0d want=0", nd); else passed++;
    // Reset beats start; then start is taken on the first edge after release
    rst_n = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_priority busy=%b want=0", busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL first_accept busy=%b want=1", busy); else passed++;
    wait_done(20, lat, bc);
    checks++;
    if (lat !== 8 || sum !== 8'h78 || cout !== 1'b0)
      $display("FAIL fresh_after_reset lat=%0d got=%b_%h want 8 0_78", lat, cout, sum);
    else passed++;
  endtask

  task automatic test_sweep8;
    int lat, bc;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      start_op(ra, rb, rc);
      wait_done(20, lat, bc);
      checks++;
      if (lat !== 8 || {cout, sum} !== exp)
        $display("FAIL sweep8 a=%h b=%h c=%b lat=%0d got=%h want lat=8 %h",
                 ra, rb, rc, lat, {cout, sum}, exp);
      else passed++;
    end
  endtask

  task automatic test_sweep_widths;
    int l16, l2, c;
    logic [16:0] e16;
    logic [2:0]  e2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wa = 16'($urandom); wb = 16'($urandom); wcin = 1'($urandom); wstart = 1'b1;
      e16 = {1'b0, wa} + {1'b0, wb} + {16'd0, wcin};
      e2  = {1'b0, wa[1:0]} + {1'b0, wb[1:0]} + {2'd0, wcin};
      @(negedge clk);
      wstart = 1'b0;
      l16 = -1; l2 = -1; c = 0;
      while (l16 < 0 && c < 30) begin
        if (w2_done && l2 < 0) l2 = c;
        if (w16_done) l16 = c;
        if (l16 < 0) begin
          @(negedge clk);
          c++;
        end
      end
      checks++;
      if (l16 !== 16 || l2 !== 2 || {w16_cout, w16_sum} !== e16 || {w2_cout, w2_sum} !== e2)
        $display("FAIL sweep_w16_w2 lat=%0d/%0d got=%h/%h want 16/2 %h/%h",
                 l16, l2, {w16_cout, w16_sum}, {w2_cout, w2_sum}, e16, e2);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    wa = '0; wb = '0; wcin = 1'b0; wstart = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep8();
    test_sweep_widths();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; the legal range SHALL be 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin an addition, sampled on the rising edge.
REQ-005 a  input  WIDTH  operand A, captured on acceptance.
REQ-006 b  input  WIDTH  operand B, captured on acceptance.
REQ-007 cin  input  1  carry-in, captured on acceptance.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse: sum and cout are valid.
REQ-010 sum  output  WIDTH  result, A+B+cin modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted on an edge where the state is IDLE or DONE.
REQ-014 On acceptance, the block SHALL load a and b into the shift registers, load the carry register from cin, clear the bit counter to 0, clear the sum register and enter RUN.
REQ-015 Each RUN cycle SHALL process one bit, LSB first, through one full-adder cell:
- the cell inputs SHALL be the operand-A LSB, the operand-B LSB and the carry register;
- the cell sum bit SHALL shift into the MSB of the sum register, which shifts right;
- the cell carry SHALL update the carry register;
- both operand registers SHALL shift right;
- the counter SHALL increment.
REQ-016 RUN SHALL go to DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1); done SHALL assert exactly WIDTH cycles after the accepting edge.
REQ-017 In DONE, done SHALL be 1 for that single cycle.
REQ-018 In DONE, start=1 SHALL be accepted (back-to-back operation, go to RUN); start=0 SHALL go to IDLE.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 start while in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-021 sum and cout SHALL hold the last completed result until the next acceptance; they SHALL NOT be defined-valid while busy=1.
REQ-022 Changes on a, b or cin after acceptance SHALL have no effect on the result in progress.
REQ-023 The counter width SHALL be $clog2(WIDTH); the counter SHALL never wrap during RUN.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL force state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and clear the operand registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 rst_n SHALL take priority over start on the same edge.
REQ-027 The first acceptance SHALL be possible on the first edge after rst_n returns to 1.

Structure
REQ-028 State encoding (IDLE/RUN/DONE typedef) SHALL live in the shared package serial_arith_pkg, together with the default WIDTH constant.
REQ-029 The bit operation SHALL be one instance of the combinational sub-module fa_cell, with ports A, B, Cin, Sum and Cout; no other arithmetic logic SHALL be used for the sum.
REQ-030 The design SHALL contain no latches, and all outputs SHALL be registered.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy for 8 cycles, done on the 8th edge after acceptance, sum=0x96, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 start pulsed again 3 cycles into RUN with a=0x11, b=0x22 -> ignored; the first result (0x5A+0x3C=0x96) completes unchanged, with exactly one done pulse.
REQ-034 start held high continuously -> in the DONE cycle the new operands are accepted, RUN follows with no IDLE gap, and the second done arrives 9 cycles after the first.
REQ-035 rst_n=0 for one edge at RUN cycle 4 -> IDLE with all outputs 0 and no done pulse; a fresh start then yields the correct sum.
REQ-036 A randomized sweep of 1000 operand/cin sets SHALL match {cout,sum} = a+b+cin with the fixed WIDTH latency, also at WIDTH=2 and WIDTH=16.
